// File: rtl/pixclk_pkg.sv
// Shared definitions for the pixel-clock generator.
// Contents: FSM state type, default increment table for the 252 MHz PLL clock,
// mode index constants and a clog2 helper that never returns less than 1.
package pixclk_pkg;

    // Generator operating states
    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        QUALIFY   = 3'd1,
        RUN       = 3'd2,
        DRAIN     = 3'd3,
        SWITCH    = 3'd4
    } pixclk_state_e;

    localparam int PIXCLK_ACC_W     = 16;
    localparam int PIXCLK_NUM_MODES = 4;

    // Mode indices into the default table
    localparam int MODE_25M2 = 0;
    localparam int MODE_42M  = 1;
    localparam int MODE_63M  = 2;
    localparam int MODE_126M = 3;

    // f_pix = 252 MHz * inc / 65536
    localparam logic [15:0] INC_25M2 = 16'd6554;
    localparam logic [15:0] INC_42M  = 16'd10923;
    localparam logic [15:0] INC_63M  = 16'd16384;
    localparam logic [15:0] INC_126M = 16'd32768;

    // Entry 0 sits in the least significant bits
    localparam logic [63:0] PIXCLK_MODE_INC_DEFAULT = {INC_126M, INC_63M, INC_42M, INC_25M2};

    // Width needed to index 'value' items, at least one bit
    function automatic int clog2_min1(input int value);
        int width_v;
        width_v = $clog2(value);
        return (width_v < 1) ? 1 : width_v;
    endfunction

endpackage

// File: rtl/lock_qualifier.sv
// Counts consecutive pll_lock-high cycles and reports when the current cycle
// completes a run of LOCK_CYCLES. Any low sample restarts the run.
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high
//   pll_lock  in   raw PLL lock, synchronous to clk
//   qualified out  high while this cycle is at least the LOCK_CYCLES-th consecutive high
module lock_qualifier #(
    parameter int LOCK_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic pll_lock,
    output logic qualified
);

    localparam int               CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Saturating run-length counter of lock-high samples
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (!pll_lock) begin
            cnt_r <= '0;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // cnt_r holds the highs seen before this cycle, so this cycle makes LOCK_CYCLES
    assign qualified = pll_lock && (cnt_r >= CNT_LAST);

endmodule

// File: rtl/pixel_clock_gen.sv
// Fractional pixel-clock generator running from the fast PLL clock.
// A phase accumulator adds the selected increment every running cycle; its
// carry becomes a one-cycle pixel enable and its MSB a ~50% duty pixel clock.
// Mode changes let the pending pulse out, insert GAP_CYCLES quiet cycles and
// restart the accumulator from zero with the new increment.
// Ports:
//   in_clk    in   fast PLL clock
//   reset     in   synchronous, active-high
//   pll_lock  in   PLL lock, synchronous to in_clk
//   mode_req  in   one-cycle request strobe for mode_sel
//   mode_sel  in   requested mode index
//   pix_ce    out  one-cycle pixel enable
//   pix_clk   out  accumulator MSB while running
//   locked    out  generator running or switching
//   busy      out  mode switch in progress
//   cur_mode  out  mode whose increment is loaded
//   mode_err  out  one-cycle pulse for an out-of-range request
module pixel_clock_gen
    import pixclk_pkg::*;
#(
    parameter int                         ACC_W        = PIXCLK_ACC_W,
    parameter int                         NUM_MODES    = PIXCLK_NUM_MODES,
    parameter int                         MODE_W       = clog2_min1(NUM_MODES),
    parameter logic [NUM_MODES*ACC_W-1:0] MODE_INC     = PIXCLK_MODE_INC_DEFAULT,
    parameter int                         DEFAULT_MODE = 0,
    parameter int                         LOCK_CYCLES  = 1024,
    parameter int                         GAP_CYCLES   = 4
) (
    input  logic              in_clk,
    input  logic              reset,
    input  logic              pll_lock,
    input  logic              mode_req,
    input  logic [MODE_W-1:0] mode_sel,
    output logic              pix_ce,
    output logic              pix_clk,
    output logic              locked,
    output logic              busy,
    output logic [MODE_W-1:0] cur_mode,
    output logic              mode_err
);

    localparam int                GAP_W        = clog2_min1(GAP_CYCLES);
    localparam logic [GAP_W-1:0]  GAP_LOAD     = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE      = GAP_W'(1);
    localparam logic [MODE_W:0]   NUM_MODES_L  = (MODE_W + 1)'(NUM_MODES);
    localparam logic [MODE_W-1:0] DEFAULT_MODE_L = MODE_W'(DEFAULT_MODE);
    localparam int                TBL_DEPTH    = 2 ** MODE_W;

    pixclk_state_e     state_r, state_n_s;
    logic [ACC_W-1:0]  acc_r, acc_n_s;
    logic [ACC_W:0]    sum_s;
    logic [ACC_W-1:0]  inc_s;
    logic [ACC_W-1:0]  inc_tbl_s [TBL_DEPTH];
    logic [MODE_W-1:0] target_r, target_n_s;
    logic [MODE_W-1:0] cur_mode_r, mode_n_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_n_s;
    logic              qualified_s;
    logic              mode_ok_s, req_ok_s;
    logic              running_n_s;
    logic              pix_ce_r, pix_clk_r, locked_r, busy_r, mode_err_r;
    logic              pix_ce_n_s, pix_clk_n_s, locked_n_s, busy_n_s, mode_err_n_s;

    lock_qualifier #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock_qualifier (
        .clk       (in_clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .qualified (qualified_s)
    );

    // Unused table slots read as 0, an increment that never produces a carry
    for (genvar g = 0; g < TBL_DEPTH; g++) begin : g_inc_tbl
        if (g < NUM_MODES) begin : g_used
            assign inc_tbl_s[g] = MODE_INC[g*ACC_W +: ACC_W];
        end else begin : g_unused
            assign inc_tbl_s[g] = '0;
        end
    end

    assign inc_s     = inc_tbl_s[cur_mode_r];
    assign sum_s     = {1'b0, acc_r} + {1'b0, inc_s};
    assign mode_ok_s = ({1'b0, mode_sel} < NUM_MODES_L);
    assign req_ok_s  = mode_req && mode_ok_s;

    // Next-state, accumulator, target and gap counter decisions
    always_comb begin
        state_n_s  = state_r;
        acc_n_s    = acc_r;
        target_n_s = target_r;
        gap_n_s    = gap_cnt_r;
        mode_n_s   = cur_mode_r;
        if (!pll_lock) begin
            // Lock loss overrides everything; only idle states may still take a mode
            state_n_s  = WAIT_LOCK;
            acc_n_s    = '0;
            target_n_s = cur_mode_r;
            gap_n_s    = '0;
            if (req_ok_s && ((state_r == WAIT_LOCK) || (state_r == QUALIFY))) begin
                mode_n_s = mode_sel;
            end else begin
                mode_n_s = cur_mode_r;
            end
        end else begin
            case (state_r)
                WAIT_LOCK: begin
                    state_n_s = QUALIFY;
                    if (req_ok_s) begin
                        mode_n_s = mode_sel;
                    end else begin
                        mode_n_s = cur_mode_r;
                    end
                end
                QUALIFY: begin
                    if (req_ok_s) begin
                        mode_n_s = mode_sel;
                    end else begin
                        mode_n_s = cur_mode_r;
                    end
                    if (qualified_s) begin
                        state_n_s = RUN;
                        acc_n_s   = '0;
                    end else begin
                        state_n_s = QUALIFY;
                    end
                end
                RUN: begin
                    acc_n_s = sum_s[ACC_W-1:0];
                    if (req_ok_s && (mode_sel != cur_mode_r)) begin
                        state_n_s  = DRAIN;
                        target_n_s = mode_sel;
                    end else begin
                        state_n_s = RUN;
                    end
                end
                DRAIN: begin
                    if (req_ok_s) begin
                        target_n_s = mode_sel;
                    end else begin
                        target_n_s = target_r;
                    end
                    // Leave only once the last old-rate pulse is on the output
                    if (pix_ce_r) begin
                        state_n_s = SWITCH;
                        acc_n_s   = '0;
                        gap_n_s   = GAP_LOAD;
                    end else begin
                        state_n_s = DRAIN;
                        acc_n_s   = sum_s[ACC_W-1:0];
                    end
                end
                SWITCH: begin
                    if (gap_cnt_r == '0) begin
                        state_n_s = RUN;
                        mode_n_s  = target_r;
                        acc_n_s   = '0;
                    end else begin
                        gap_n_s = gap_cnt_r - GAP_ONE;
                        if (req_ok_s) begin
                            target_n_s = mode_sel;
                        end else begin
                            target_n_s = target_r;
                        end
                    end
                end
                default: begin
                    state_n_s = WAIT_LOCK;
                    acc_n_s   = '0;
                end
            endcase
        end
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        running_n_s  = (state_n_s == RUN) || (state_n_s == DRAIN);
        pix_ce_n_s   = sum_s[ACC_W] && running_n_s && ((state_r == RUN) || (state_r == DRAIN));
        pix_clk_n_s  = running_n_s && acc_n_s[ACC_W-1];
        locked_n_s   = running_n_s || (state_n_s == SWITCH);
        busy_n_s     = (state_n_s == DRAIN) || (state_n_s == SWITCH);
        mode_err_n_s = mode_req && !mode_ok_s;
    end

    // State, datapath and registered outputs
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_r    <= WAIT_LOCK;
            acc_r      <= '0;
            target_r   <= DEFAULT_MODE_L;
            gap_cnt_r  <= '0;
            cur_mode_r <= DEFAULT_MODE_L;
            pix_ce_r   <= 1'b0;
            pix_clk_r  <= 1'b0;
            locked_r   <= 1'b0;
            busy_r     <= 1'b0;
            mode_err_r <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            acc_r      <= acc_n_s;
            target_r   <= target_n_s;
            gap_cnt_r  <= gap_n_s;
            cur_mode_r <= mode_n_s;
            pix_ce_r   <= pix_ce_n_s;
            pix_clk_r  <= pix_clk_n_s;
            locked_r   <= locked_n_s;
            busy_r     <= busy_n_s;
            mode_err_r <= mode_err_n_s;
        end
    end

    assign pix_ce   = pix_ce_r;
    assign pix_clk  = pix_clk_r;
    assign locked   = locked_r;
    assign busy     = busy_r;
    assign cur_mode = cur_mode_r;
    assign mode_err = mode_err_r;

endmodule
